// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Turns debounced key press/release events into single-click, double-click
//   and long-press pulses. One instance per key.
//
//   Optional feature macro: KEY_REPEAT_EN
//     defined   : repeat_pulse fires every REPEAT_MS while the key is long-held
//     undefined : no repeat logic is built and repeat_pulse is tied to 0
//
// Ports
//   clk_50mhz     in   system clock
//   rst_n         in   asynchronous reset, active low
//   key_flag      in   1-cycle event strobe from the debouncer
//   key_state     in   debounced level (1 = released, 0 = pressed)
//   click_pulse   out  1-cycle pulse, single click confirmed
//   double_pulse  out  1-cycle pulse, double click confirmed
//   long_pulse    out  1-cycle pulse, long-press threshold reached
//   repeat_pulse  out  1-cycle pulse, auto-repeat tick while long-held
//   key_held      out  1 while the key is considered pressed
module key_event_decoder #(
  parameter int CNT_1MS   = 49_999,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic key_flag,
  input  logic key_state,
  output logic click_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic key_held
);

  // All timing values must fit the 16-bit counters.
  if (CNT_1MS < 1 || CNT_1MS > 65535 || LONG_MS < 1 || LONG_MS > 65535 ||
      DOUBLE_MS < 1 || DOUBLE_MS > 65535 || REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_param_chk
    $error("key_event_decoder: timing parameter out of 16-bit range");
  end

  localparam logic [15:0] TERM_1MS = 16'(CNT_1MS);
  localparam logic [15:0] LONG_T   = 16'(LONG_MS);
  localparam logic [15:0] DOUBLE_T = 16'(DOUBLE_MS);

  typedef enum logic [4:0] {
    IDLE        = 5'b00001,
    PRESSED     = 5'b00010,
    WAIT_SECOND = 5'b00100,
    SECOND_DOWN = 5'b01000,
    LONG_HELD   = 5'b10000
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] presc, ms_cnt;
  logic        ms_tick, key_press, key_release, cnt_clr;
  logic        click_nxt, double_nxt, long_nxt, held_nxt, repeat_nxt;

  assign key_press   = key_flag & ~key_state;
  assign key_release = key_flag &  key_state;
  assign ms_tick     = (presc == TERM_1MS);

  always_comb begin
    state_nxt  = state;
    click_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    // Event checks come before timer checks so a release on the LONG_MS
    // cycle stays a short press and a press on the DOUBLE_MS cycle is a
    // double click. Events illegal in a state simply fall through.
    case (state)
      IDLE:        if (key_press) state_nxt = PRESSED;
      PRESSED:
        if (key_release) state_nxt = WAIT_SECOND;
        else if (ms_cnt == LONG_T) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end
      WAIT_SECOND:
        if (key_press) state_nxt = SECOND_DOWN;
        else if (ms_cnt == DOUBLE_T) begin
          state_nxt = IDLE;
          click_nxt = 1'b1;
        end
      SECOND_DOWN:
        if (key_release) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end
      LONG_HELD:
        if (key_release) state_nxt = IDLE;
`ifdef KEY_REPEAT_EN
        else if (ms_cnt == 16'(REPEAT_MS)) repeat_nxt = 1'b1;
`endif
      default:     state_nxt = IDLE;
    endcase
    held_nxt = (state_nxt == PRESSED) || (state_nxt == SECOND_DOWN) ||
               (state_nxt == LONG_HELD);
    // Timebase restarts on every state change and on each repeat tick.
    cnt_clr  = (state_nxt != state) || repeat_nxt;
  end

  // 1 ms prescaler and saturating millisecond counter
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (cnt_clr) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (ms_tick) begin
      presc  <= '0;
      if (ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 16'd1;
    end else begin
      presc  <= presc + 16'd1;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      click_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      state        <= state_nxt;
      click_pulse  <= click_nxt;
      double_pulse <= double_nxt;
      long_pulse   <= long_nxt;
      key_held     <= held_nxt;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) repeat_pulse <= 1'b0;
    else        repeat_pulse <= repeat_nxt;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
